// File: rtl/conv1_row_accum_if.sv
// Beat input / result output bundle for conv1_row_accum.
// The DUT attaches to the slave modport; the upstream/downstream side drives master.
interface conv1_row_accum_if #(
  parameter int unsigned NUM_INPUTS  = 5,
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned KERNEL_ROWS = 5,
  parameter int unsigned ACC_WIDTH   = IN_WIDTH + $clog2(NUM_INPUTS*KERNEL_ROWS) + 1
);
  logic                             accum_clr_i;
  logic signed [IN_WIDTH-1:0]       accum_bias_i;
  logic                             accum_in_valid_i;
  logic                             accum_in_ready_o;
  logic [NUM_INPUTS*IN_WIDTH-1:0]   accum_in_i;
  logic                             accum_out_valid_o;
  logic                             accum_out_ready_i;
  logic signed [ACC_WIDTH-1:0]      accum_out_o;
  logic                             accum_busy_o;

  modport master (
    output accum_clr_i, accum_bias_i, accum_in_valid_i, accum_in_i, accum_out_ready_i,
    input  accum_in_ready_o, accum_out_valid_o, accum_out_o, accum_busy_o
  );

  modport slave (
    input  accum_clr_i, accum_bias_i, accum_in_valid_i, accum_in_i, accum_out_ready_i,
    output accum_in_ready_o, accum_out_valid_o, accum_out_o, accum_busy_o
  );
endinterface

// File: rtl/conv1_row_accum.sv
// Sums one kernel row of partial products per beat over KERNEL_ROWS beats, adds bias,
// and emits one pixel per window. Define CONV1_ACCUM_RELU_EN to clamp results at zero.
module conv1_row_accum #(
  parameter int unsigned NUM_INPUTS  = 5,
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned KERNEL_ROWS = 5,
  parameter int unsigned ACC_WIDTH   = IN_WIDTH + $clog2(NUM_INPUTS*KERNEL_ROWS) + 1
) (
  input logic               accum_clk,
  input logic               accum_rst,
  conv1_row_accum_if.slave  bus
);

  localparam int unsigned CntW = (KERNEL_ROWS > 1) ? $clog2(KERNEL_ROWS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(KERNEL_ROWS - 1);
  localparam int unsigned ExtW = ACC_WIDTH - IN_WIDTH;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] out_q, out_d;

  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        last_beat;
  logic                        in_ready;
  logic                        accept;
  logic                        complete;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      lane_sum = lane_sum + {{ExtW{bus.accum_in_i[i*IN_WIDTH + IN_WIDTH - 1]}},
                             bus.accum_in_i[i*IN_WIDTH +: IN_WIDTH]};
    end
  end

  assign bias_ext  = {{ExtW{bus.accum_bias_i[IN_WIDTH-1]}}, bus.accum_bias_i};
  assign last_beat = (cnt_q == LastCnt);

  // Only the closing beat of a window needs room in the output register.
  assign in_ready = !bus.accum_clr_i &&
                    !(out_valid_q && !bus.accum_out_ready_i && last_beat);
  assign accept   = bus.accum_in_valid_i && in_ready;
  assign complete = accept && last_beat;

  // The first beat of a window starts from bias instead of the running sum.
  assign acc_next = ((state_q == StIdle) ? bias_ext : acc_q) + lane_sum;

`ifdef CONV1_ACCUM_RELU_EN
  assign result = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
  assign result = acc_next;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (bus.accum_clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (accept) begin
      acc_d = acc_next;
      if (last_beat) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StRun;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (complete) begin
      out_valid_d = 1'b1;
      out_d       = result;
    end else if (out_valid_q && bus.accum_out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge accum_clk or posedge accum_rst) begin
    if (accum_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.accum_in_ready_o  = in_ready;
  assign bus.accum_out_valid_o = out_valid_q;
  assign bus.accum_out_o       = out_q;
  assign bus.accum_busy_o      = (cnt_q != '0);

endmodule
